// File: rtl/xgmii_66b_pkg.sv
// Shared constants and types for the XGMII -> 64b/66b transmit encoder.
// Holds XGMII control characters, block type fields, 7-bit control codes,
// sync headers, the transmit FSM state enum and the default scrambler seed.
package xgmii_66b_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned LANES  = 8;
  localparam int unsigned SCR_W  = 58;

  // XGMII control characters
  localparam logic [7:0] XG_I = 8'h07;
  localparam logic [7:0] XG_S = 8'hFB;
  localparam logic [7:0] XG_T = 8'hFD;
  localparam logic [7:0] XG_E = 8'hFE;
  localparam logic [7:0] XG_O = 8'h9C;

  // Block type fields
  localparam logic [7:0] BT_C  = 8'h1E;
  localparam logic [7:0] BT_S0 = 8'h78;
  localparam logic [7:0] BT_S4 = 8'h33;
  localparam logic [7:0] BT_O0 = 8'h4B;

  // 7-bit control codes
  localparam logic [6:0] CC_I = 7'h00;
  localparam logic [6:0] CC_E = 7'h1E;

  // Sync headers
  localparam logic [1:0] HDR_CTRL = 2'b01;
  localparam logic [1:0] HDR_DATA = 2'b10;

  // Error block: control type with every code set to E
  localparam logic [DATA_W-1:0] EBLOCK = {{8{CC_E}}, BT_C};

  localparam logic [SCR_W-1:0] SCR_SEED_DEF = 58'h3FF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_e;
  typedef enum logic [2:0] {L_D, L_I, L_S, L_T, L_O, L_E} lane_e;
  typedef enum logic [2:0] {COL_C, COL_S, COL_O, COL_D, COL_T, COL_E} col_e;

  // Per-lane character class; unknown control bytes are treated as E
  function automatic lane_e lane_class(input logic [7:0] b, input logic c);
    lane_e r;
    if (!c) begin
      r = L_D;
    end else begin
      case (b)
        XG_I:    r = L_I;
        XG_S:    r = L_S;
        XG_T:    r = L_T;
        XG_O:    r = L_O;
        default: r = L_E;
      endcase
    end
    return r;
  endfunction

  // Block type for a terminate in lane k
  function automatic logic [7:0] t_type(input logic [2:0] k);
    logic [7:0] r;
    case (k)
      3'd0:    r = 8'h87;
      3'd1:    r = 8'h99;
      3'd2:    r = 8'hAA;
      3'd3:    r = 8'hB4;
      3'd4:    r = 8'hCC;
      3'd5:    r = 8'hD2;
      3'd6:    r = 8'hE1;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/xgmii_66b_encoder_fsm_scrambler_58.sv
// x^58+x^39+1 self-synchronous scrambler, 64 bits per clock, LSB first.
// Also forms the registered output stage: header, valid and error flags are
// carried alongside the payload. With bypass_i set the payload passes
// unscrambled and the scrambler state is frozen.
// Ports: clk_i/rst_i (sync, active high), vld_i, bypass_i, data_i, head_i,
//        err_i in; data_o, head_o, vld_o, err_o registered out.
module scrambler_58
  import xgmii_66b_pkg::*;
#(
  parameter logic [SCR_W-1:0] SEED = SCR_SEED_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vld_i,
  input  logic              bypass_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        head_i,
  input  logic              err_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        head_o,
  output logic              vld_o,
  output logic              err_o
);

  localparam int unsigned TAP_A = 38;
  localparam int unsigned TAP_B = 57;

  logic [SCR_W-1:0]  state_q, state_d;
  logic [DATA_W-1:0] scr_d;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        head_q;
  logic              vld_q, err_q;

  // Serial recurrence unrolled over 64 bits; each output bit feeds the shift
  always_comb begin
    state_d = state_q;
    scr_d   = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      scr_d[i] = data_i[i] ^ state_d[TAP_A] ^ state_d[TAP_B];
      state_d  = {state_d[SCR_W-2:0], scr_d[i]};
    end
  end

  // Output stage; holds payload/header across invalid cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
      data_q  <= '0;
      head_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (vld_i) begin
      if (!bypass_i) state_q <= state_d;
      data_q <= bypass_i ? data_i : scr_d;
      head_q <= head_i;
      vld_q  <= 1'b1;
      err_q  <= err_i;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign head_o = head_q;
  assign vld_o  = vld_q;
  assign err_o  = err_q;

endmodule

// File: rtl/xgmii_66b_encoder_fsm.sv
// 64b/66b transmit encoder: classifies each XGMII column, sequences blocks
// with the transmit FSM (illegal sequences become error blocks), optionally
// scrambles the payload and keeps a saturating error-block counter.
// Ports: clk_i, rst_i (sync, active high); xgmii_txd_i/txc_i/txd_vld_i in;
//        encode_data_o/head_o/data_vld_o/error_o and err_cnt_o out.
// Latency is 1 cycle with the scrambler disabled, 2 cycles with it enabled.
module xgmii_66b_encoder_fsm
  import xgmii_66b_pkg::*;
#(
  parameter bit               SCRAMBLE_EN = 1'b1,
  parameter int unsigned      ERR_CNT_W   = 16,
  parameter logic [SCR_W-1:0] SCR_SEED    = SCR_SEED_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_W-1:0]    xgmii_txd_i,
  input  logic [LANES-1:0]     xgmii_txc_i,
  input  logic                 xgmii_txd_vld_i,
  output logic [DATA_W-1:0]    encode_data_o,
  output logic [1:0]           encode_head_o,
  output logic                 encode_data_vld_o,
  output logic                 encode_error_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  lane_e             lane_c [LANES];
  col_e              col;
  tx_state_e         state_q, state_d;
  logic              all_d, all_ie, is_s0, is_s4, is_o0, is_t, t_match;
  logic [2:0]        t_k;
  logic [DATA_W-1:0] blk_data;
  logic [1:0]        blk_head;
  logic              blk_err;

  logic [DATA_W-1:0]    s_data;
  logic [1:0]           s_head;
  logic                 s_vld, s_err;
  logic [ERR_CNT_W-1:0] cnt_q;

  // Lane classification
  always_comb begin
    for (int k = 0; k < int'(LANES); k++) begin
      lane_c[k] = lane_class(xgmii_txd_i[8*k +: 8], xgmii_txc_i[k]);
    end
  end

  // Column pattern detection
  always_comb begin
    all_d   = 1'b1;
    all_ie  = 1'b1;
    is_s0   = (lane_c[0] == L_S);
    is_s4   = (lane_c[4] == L_S);
    is_o0   = (lane_c[0] == L_O);
    is_t    = 1'b0;
    t_match = 1'b0;
    t_k     = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (lane_c[k] != L_D) all_d = 1'b0;
      if (lane_c[k] != L_I && lane_c[k] != L_E) all_ie = 1'b0;
      if (k >= 1 && lane_c[k] != L_D) is_s0 = 1'b0;
      if (k <= 3 && lane_c[k] != L_I) is_s4 = 1'b0;
      if (k >= 5 && lane_c[k] != L_D) is_s4 = 1'b0;
      if (k >= 1 && k <= 3 && lane_c[k] != L_D) is_o0 = 1'b0;
      if (k >= 4 && lane_c[k] != L_I) is_o0 = 1'b0;
    end
    // Terminate in lane k: data below, idle above
    for (int k = 0; k < int'(LANES); k++) begin
      t_match = (lane_c[k] == L_T);
      for (int j = 0; j < int'(LANES); j++) begin
        if (j < k && lane_c[j] != L_D) t_match = 1'b0;
        if (j > k && lane_c[j] != L_I) t_match = 1'b0;
      end
      if (t_match) begin
        is_t = 1'b1;
        t_k  = 3'(k);
      end
    end
  end

  // Block formation, next-state and error substitution
  always_comb begin
    col      = COL_E;
    blk_data = EBLOCK;
    blk_head = HDR_CTRL;
    if (all_d) begin
      col      = COL_D;
      blk_data = xgmii_txd_i;
      blk_head = HDR_DATA;
    end else if (all_ie) begin
      col      = COL_C;
      blk_data = {56'h0, BT_C};
      for (int k = 0; k < int'(LANES); k++) begin
        blk_data[8+7*k +: 7] = (lane_c[k] == L_I) ? CC_I : CC_E;
      end
    end else if (is_s0) begin
      col      = COL_S;
      blk_data = {xgmii_txd_i[63:8], BT_S0};
    end else if (is_s4) begin
      col      = COL_S;
      blk_data = {xgmii_txd_i[63:40], 32'h0, BT_S4};
    end else if (is_o0) begin
      col      = COL_O;
      blk_data = {32'h0, xgmii_txd_i[31:8], BT_O0};
    end else if (is_t) begin
      col      = COL_T;
      blk_data = {56'h0, t_type(t_k)};
      for (int j = 0; j < int'(LANES) - 1; j++) begin
        if (j < int'(t_k)) blk_data[8+8*j +: 8] = xgmii_txd_i[8*j +: 8];
      end
    end

    state_d = TX_E;
    case (state_q)
      TX_INIT: begin
        if (col == COL_C)      state_d = TX_C;
        else if (col == COL_S) state_d = TX_D;
      end
      TX_C, TX_T: begin
        if (col == COL_C || col == COL_O) state_d = TX_C;
        else if (col == COL_S)            state_d = TX_D;
      end
      TX_D: begin
        if (col == COL_D)      state_d = TX_D;
        else if (col == COL_T) state_d = TX_T;
      end
      TX_E: begin
        if (col == COL_D)                      state_d = TX_D;
        else if (col == COL_T)                 state_d = TX_T;
        else if (col == COL_C || col == COL_O) state_d = TX_C;
        else if (col == COL_S)                 state_d = TX_D;
      end
      default: state_d = TX_E;
    endcase

    blk_err = (state_d == TX_E);
    if (blk_err) begin
      blk_data = EBLOCK;
      blk_head = HDR_CTRL;
    end
  end

  // FSM state advances on valid columns only
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= TX_INIT;
    end else if (xgmii_txd_vld_i) begin
      state_q <= state_d;
    end
  end

  // Extra pipeline stage ahead of the scrambler when it is enabled
  if (SCRAMBLE_EN) begin : g_pipe
    logic [DATA_W-1:0] p_data_q;
    logic [1:0]        p_head_q;
    logic              p_vld_q, p_err_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        p_data_q <= '0;
        p_head_q <= '0;
        p_vld_q  <= 1'b0;
        p_err_q  <= 1'b0;
      end else if (xgmii_txd_vld_i) begin
        p_data_q <= blk_data;
        p_head_q <= blk_head;
        p_vld_q  <= 1'b1;
        p_err_q  <= blk_err;
      end else begin
        p_vld_q <= 1'b0;
        p_err_q <= 1'b0;
      end
    end

    assign s_data = p_data_q;
    assign s_head = p_head_q;
    assign s_vld  = p_vld_q;
    assign s_err  = p_err_q;
  end else begin : g_nopipe
    assign s_data = blk_data;
    assign s_head = blk_head;
    assign s_vld  = xgmii_txd_vld_i;
    assign s_err  = blk_err;
  end

  scrambler_58 #(
    .SEED(SCR_SEED)
  ) u_scr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .vld_i    (s_vld),
    .bypass_i (!SCRAMBLE_EN),
    .data_i   (s_data),
    .head_i   (s_head),
    .err_i    (s_err),
    .data_o   (encode_data_o),
    .head_o   (encode_head_o),
    .vld_o    (encode_data_vld_o),
    .err_o    (encode_error_o)
  );

  // Counter updates on the same edge that registers the error pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (s_vld && s_err && cnt_q != '1) begin
      cnt_q <= cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_xgmii_66b_encoder_fsm.sv
// Bench for xgmii_66b_encoder_fsm: an unscrambled instance with a 2-bit
// counter and a scrambled instance with the default counter see the same
// columns; expected blocks are queued at drive time and popped on output.
module tb_xgmii_66b_encoder_fsm;

  logic        clk = 1'b0;
  logic        rst, vld;
  logic [63:0] txd;
  logic [7:0]  txc;

  logic [63:0] d0_data, d1_data;
  logic [1:0]  d0_head, d1_head;
  logic        d0_vld, d1_vld, d0_err, d1_err;
  logic [1:0]  d0_cnt;
  logic [15:0] d1_cnt;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  head;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          total = 0, bad = 0, cyc = 0;
  int          cnt0_exp = 0, cnt1_exp = 0;
  bit          mon_en = 1'b0;
  logic [57:0] scr_s;
  logic [63:0] prev0 = '0, prev1 = '0;
  logic        rst_prev = 1'b1;

  localparam logic [63:0] IDLE = 64'h0707070707070707;
  localparam logic [63:0] EBLK = {{8{7'h1E}}, 8'h1E};
  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xgmii_66b_encoder_fsm #(.SCRAMBLE_EN(1'b0), .ERR_CNT_W(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .xgmii_txd_i(txd), .xgmii_txc_i(txc),
    .xgmii_txd_vld_i(vld), .encode_data_o(d0_data), .encode_head_o(d0_head),
    .encode_data_vld_o(d0_vld), .encode_error_o(d0_err), .err_cnt_o(d0_cnt));

  xgmii_66b_encoder_fsm #(.SCRAMBLE_EN(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .xgmii_txd_i(txd), .xgmii_txc_i(txc),
    .xgmii_txd_vld_i(vld), .encode_data_o(d1_data), .encode_head_o(d1_head),
    .encode_data_vld_o(d1_vld), .encode_error_o(d1_err), .err_cnt_o(d1_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference scrambler: s[0] newest bit, taps at 38 and 57
  task automatic scr_step(input logic [63:0] d, output logic [63:0] o);
    logic fb;
    o = '0;
    for (int i = 0; i < 64; i++) begin
      fb    = scr_s[38] ^ scr_s[57];
      o[i]  = d[i] ^ fb;
      scr_s = {scr_s[56:0], o[i]};
    end
  endtask

  task automatic col(input logic [63:0] d, input logic [7:0] c,
                     input logic [63:0] ed, input logic [1:0] eh, input logic ee);
    exp_t        x;
    logic [63:0] sd;
    @(posedge clk); #1;
    txd = d; txc = c; vld = 1'b1;
    x.data = ed; x.head = eh; x.err = ee; x.due = cyc + 1;
    q0.push_back(x);
    scr_step(ed, sd);
    x.data = sd; x.due = cyc + 2;
    q1.push_back(x);
  endtask

  task automatic gap();
    @(posedge clk); #1;
    vld = 1'b0;
    txd = {$urandom, $urandom};
    txc = 8'($urandom);
  endtask

  task automatic do_reset();
    repeat (3) gap();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst.d0_data", d0_data, 64'h0);
    chk("rst.d0_head", 64'(d0_head), 64'h0);
    chk("rst.d0_vld",  64'(d0_vld), 64'h0);
    chk("rst.d0_err",  64'(d0_err), 64'h0);
    chk("rst.d0_cnt",  64'(d0_cnt), 64'h0);
    chk("rst.d1_data", d1_data, 64'h0);
    chk("rst.d1_head", 64'(d1_head), 64'h0);
    chk("rst.d1_vld",  64'(d1_vld), 64'h0);
    chk("rst.d1_err",  64'(d1_err), 64'h0);
    chk("rst.d1_cnt",  64'(d1_cnt), 64'h0);
    rst = 1'b0;
    scr_s = SEED;
    cnt0_exp = 0;
    cnt1_exp = 0;
    q0.delete();
    q1.delete();
    mon_en = 1'b1;
  endtask

  task automatic cmp(input string who, input exp_t x, input logic [63:0] d,
                     input logic [1:0] h, input logic e);
    chk({who, ".data"}, d, x.data);
    chk({who, ".head"}, 64'(h), 64'(x.head));
    chk({who, ".err"},  64'(e), 64'(x.err));
    chk({who, ".latency"}, 64'(cyc), 64'(x.due));
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (d0_vld === 1'b1) begin
        total++;
        assert (q0.size() != 0) else begin
          bad++;
          $error("FAIL d0.unexpected observed=%h expected=none", d0_data);
        end
        if (q0.size() != 0) begin
          exp_t x;
          x = q0.pop_front();
          cmp("d0", x, d0_data, d0_head, d0_err);
          if (x.err && cnt0_exp < 3) cnt0_exp++;
          chk("d0.err_cnt", 64'(d0_cnt), 64'(cnt0_exp));
        end
      end else begin
        chk("d0.err_idle", 64'(d0_err), 64'h0);
        if (!rst && !rst_prev) chk("d0.hold", d0_data, prev0);
        if (q0.size() != 0) begin
          total++;
          assert (q0[0].due > cyc) else begin
            bad++;
            $error("FAIL d0.missing observed=no_valid expected=%h", q0[0].data);
            void'(q0.pop_front());
          end
        end
      end
      if (d1_vld === 1'b1) begin
        total++;
        assert (q1.size() != 0) else begin
          bad++;
          $error("FAIL d1.unexpected observed=%h expected=none", d1_data);
        end
        if (q1.size() != 0) begin
          exp_t x;
          x = q1.pop_front();
          cmp("d1", x, d1_data, d1_head, d1_err);
          if (x.err && cnt1_exp < 65535) cnt1_exp++;
          chk("d1.err_cnt", 64'(d1_cnt), 64'(cnt1_exp));
        end
      end else begin
        chk("d1.err_idle", 64'(d1_err), 64'h0);
        if (!rst && !rst_prev) chk("d1.hold", d1_data, prev1);
        if (q1.size() != 0) begin
          total++;
          assert (q1[0].due > cyc) else begin
            bad++;
            $error("FAIL d1.missing observed=no_valid expected=%h", q1[0].data);
            void'(q1.pop_front());
          end
        end
      end
    end
    prev0    <= d0_data;
    prev1    <= d1_data;
    rst_prev <= rst;
  end

  initial begin
    rst = 1'b1; vld = 1'b0; txd = '0; txc = '0; scr_s = SEED;
    do_reset();

    // Idle columns
    repeat (8) col(IDLE, 8'hFF, 64'h1E, 2'b01, 1'b0);

    // Frame S0, D, gap, D, T3, then idle
    col(64'hD5555555555555FB, 8'h01, 64'hD555555555555578, 2'b01, 1'b0);
    col(64'h0123456789ABCDEF, 8'h00, 64'h0123456789ABCDEF, 2'b10, 1'b0);
    gap(); gap();
    col(64'hFEDCBA9876543210, 8'h00, 64'hFEDCBA9876543210, 2'b10, 1'b0);
    col(64'h07070707FDCCBBAA, 8'hF8, 64'h00000000CCBBAAB4, 2'b01, 1'b0);
    col(IDLE, 8'hFF, 64'h1E, 2'b01, 1'b0);

    // T0 while idle is illegal, then idle recovers
    col(64'h07070707070707FD, 8'hFF, EBLK, 2'b01, 1'b1);
    col(IDLE, 8'hFF, 64'h1E, 2'b01, 1'b0);

    // S4, D, T7, O0, control block with an E lane
    col(64'h332211FB07070707, 8'h1F, 64'h3322110000000033, 2'b01, 1'b0);
    col(64'h0011223344556677, 8'h00, 64'h0011223344556677, 2'b10, 1'b0);
    col(64'hFD66554433221100, 8'h80, 64'h66554433221100FF, 2'b01, 1'b0);
    col(64'h07070707CCBBAA9C, 8'hF1, 64'h00000000CCBBAA4B, 2'b01, 1'b0);
    gap();
    col(64'h0707070707FE0707, 8'hFF, 64'h000000000780001E, 2'b01, 1'b0);

    // D while idle is illegal; T after error is accepted; D after T illegal
    col(64'h1122334455667788, 8'h00, EBLK, 2'b01, 1'b1);
    col(64'h07070707FDCCBBAA, 8'hF8, 64'h00000000CCBBAAB4, 2'b01, 1'b0);
    col(64'h8877665544332211, 8'h00, EBLK, 2'b01, 1'b1);

    // Unknown control bytes; narrow counter saturates
    repeat (5) col(64'h1111111111111155, 8'h01, EBLK, 2'b01, 1'b1);
    col(IDLE, 8'hFF, 64'h1E, 2'b01, 1'b0);

    // Reset mid-frame: following D is judged from init
    col(64'hD5555555555555FB, 8'h01, 64'hD555555555555578, 2'b01, 1'b0);
    do_reset();
    col(64'h0123456789ABCDEF, 8'h00, EBLK, 2'b01, 1'b1);
    col(64'h07070707FDCCBBAA, 8'hF8, 64'h00000000CCBBAAB4, 2'b01, 1'b0);
    col(IDLE, 8'hFF, 64'h1E, 2'b01, 1'b0);

    // T straight after reset, then ordered set recovers
    do_reset();
    col(64'h07070707FDCCBBAA, 8'hF8, EBLK, 2'b01, 1'b1);
    col(64'h07070707CCBBAA9C, 8'hF1, 64'h00000000CCBBAA4B, 2'b01, 1'b0);
    col(IDLE, 8'hFF, 64'h1E, 2'b01, 1'b0);

    repeat (6) gap();
    total++;
    assert (q0.size() == 0 && q1.size() == 0) else begin
      bad++;
      $error("FAIL drain observed=%0d/%0d expected=0/0", q0.size(), q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
